// File: rtl/n_bin_accum_serializer_if.sv
// Stream bundle for n_bin_accum_serializer: parallel-bin frame input and N_OUT-bit word output.
// slave = the averager, master = frame source plus downstream word sink.
interface n_bin_accum_serializer_if #(
  parameter int N     = 16,
  parameter int BINS  = 4,
  parameter int N_OUT = 8
);
  logic              in_valid;
  logic [BINS*N-1:0] in_data;
  logic [N_OUT-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave  (input  in_valid, in_data, out_ready,
                  output out_data, out_valid, out_last);
  modport master (output in_valid, in_data, out_ready,
                  input  out_data, out_valid, out_last);
endinterface

// File: rtl/n_bin_accum_serializer.sv
// Runtime-configurable N-bin frame averager with snapshot buffer and MSB-first word serialiser.
// Optional macro NBIN_ROUND_EN: round-half-up with saturation instead of truncating shift.
module n_bin_accum_serializer #(
  parameter int N            = 16,
  parameter int BINS         = 4,
  parameter int N_OUT        = 8,
  parameter int MAX_LOG_AVGS = 7,
  parameter int SUM_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              srst_n,
  input  logic [$clog2(MAX_LOG_AVGS+1)-1:0] log_avgs,
  output logic                              overflow,
  output logic                              busy,
  n_bin_accum_serializer_if.slave           bus
);
  localparam int LW = $clog2(MAX_LOG_AVGS + 1);
  localparam int CW = MAX_LOG_AVGS + 1;
  localparam int SW = BINS * N;
  localparam int W  = SW / N_OUT;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  if (SUM_WIDTH < N + MAX_LOG_AVGS) begin : g_sum_width_chk
    $error("SUM_WIDTH must be at least N+MAX_LOG_AVGS");
  end
  if ((N % N_OUT) != 0) begin : g_n_out_chk
    $error("N must be a multiple of N_OUT");
  end

  typedef enum logic {ACC_IDLE, ACC_RUN}  acc_state_e;
  typedef enum logic {DR_EMPTY, DR_SEND}  dr_state_e;

  acc_state_e           acc_state_q, acc_state_d;
  dr_state_e            dr_state_q, dr_state_d;
  logic [LW-1:0]        l_q, l_d, l_eff_s, log_clamp_s;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_base_s;
  logic [SUM_WIDTH-1:0] acc_q [BINS];
  logic [SUM_WIDTH-1:0] acc_d [BINS];
  logic [SUM_WIDTH-1:0] sum_s [BINS];
  logic [N-1:0]         avg_s [BINS];
  logic [SW-1:0]        snap_load_s, sh_q, sh_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 complete_s, xfer_s;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                 overflow_q, overflow_d, busy_q, busy_d;

  if (((1 << LW) - 1) > MAX_LOG_AVGS) begin : g_clamp
    assign log_clamp_s = (log_avgs > LW'(MAX_LOG_AVGS)) ? LW'(MAX_LOG_AVGS) : log_avgs;
  end else begin : g_no_clamp
    assign log_clamp_s = log_avgs;
  end

  // Accumulate FSM next state: the first frame of a period latches the average count.
  always_comb begin
    acc_state_d = acc_state_q;
    l_d         = l_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    l_eff_s     = (acc_state_q == ACC_IDLE) ? log_clamp_s : l_q;
    cnt_base_s  = (acc_state_q == ACC_IDLE) ? CW'(0) : cnt_q;
    for (int b = 0; b < BINS; b++) begin
      sum_s[b] = ((acc_state_q == ACC_IDLE) ? SUM_WIDTH'(0) : acc_q[b])
               + SUM_WIDTH'(bus.in_data[b*N +: N]);
    end
    complete_s = bus.in_valid && ((cnt_base_s + CW'(1)) == (CW'(1) << l_eff_s));
    if (complete_s) begin
      acc_state_d = ACC_IDLE;
      cnt_d       = CW'(0);
      l_d         = l_eff_s;
      for (int b = 0; b < BINS; b++) begin
        acc_d[b] = SUM_WIDTH'(0);
      end
    end else if (bus.in_valid) begin
      acc_state_d = ACC_RUN;
      cnt_d       = cnt_base_s + CW'(1);
      l_d         = l_eff_s;
      acc_d       = sum_s;
    end else begin
      acc_state_d = acc_state_q;
    end
    busy_d = (acc_state_d == ACC_RUN);
  end

`ifdef NBIN_ROUND_EN
  logic [SUM_WIDTH:0] rnd_s   [BINS];
  logic [SUM_WIDTH:0] shift_s [BINS];

  // Rounded average: half an LSB added before the shift, clipped to the N-bit range.
  always_comb begin
    for (int b = 0; b < BINS; b++) begin
      rnd_s[b]   = (l_eff_s == LW'(0)) ? (SUM_WIDTH+1)'(0)
                                       : ((SUM_WIDTH+1)'(1) << (l_eff_s - LW'(1)));
      shift_s[b] = ({1'b0, sum_s[b]} + rnd_s[b]) >> l_eff_s;
      if (|shift_s[b][SUM_WIDTH:N]) begin
        avg_s[b] = {N{1'b1}};
      end else begin
        avg_s[b] = shift_s[b][N-1:0];
      end
    end
  end
`else
  // Truncated average of the current period including this cycle's frame.
  always_comb begin
    for (int b = 0; b < BINS; b++) begin
      avg_s[b] = N'(sum_s[b] >> l_eff_s);
    end
  end
`endif

  // Snapshot packing puts bin 0 in the top bits so the drain simply shifts left.
  always_comb begin
    snap_load_s = '0;
    for (int b = 0; b < BINS; b++) begin
      snap_load_s[SW-1-b*N -: N] = avg_s[b];
    end
  end

  // Drain FSM next state: load on completion, shift per accepted word, flag lost averages.
  always_comb begin
    dr_state_d  = dr_state_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    xfer_s      = out_valid_q && bus.out_ready;
    case (dr_state_q)
      DR_EMPTY: begin
        if (complete_s) begin
          dr_state_d  = DR_SEND;
          sh_d        = snap_load_s;
          idx_d       = IW'(0);
          out_valid_d = 1'b1;
          out_last_d  = (W == 1);
        end else begin
          out_valid_d = 1'b0;
        end
      end
      DR_SEND: begin
        if (xfer_s && out_last_q) begin
          if (complete_s) begin
            sh_d        = snap_load_s;
            idx_d       = IW'(0);
            out_valid_d = 1'b1;
            out_last_d  = (W == 1);
          end else begin
            dr_state_d  = DR_EMPTY;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end else if (xfer_s) begin
          sh_d       = sh_q << N_OUT;
          idx_d      = idx_q + IW'(1);
          out_last_d = (idx_q == IW'(W - 2));
        end else begin
          sh_d = sh_q;
        end
        if (complete_s && !(xfer_s && out_last_q)) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
      end
      default: begin
        dr_state_d  = DR_EMPTY;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      acc_state_q <= ACC_IDLE;
      dr_state_q  <= DR_EMPTY;
      l_q         <= LW'(0);
      cnt_q       <= CW'(0);
      for (int b = 0; b < BINS; b++) begin
        acc_q[b] <= SUM_WIDTH'(0);
      end
      sh_q        <= SW'(0);
      idx_q       <= IW'(0);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      dr_state_q  <= dr_state_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_data  = sh_q[SW-1 -: N_OUT];
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;
endmodule

// File: doc/n_bin_accum_serializer.md
Name: n_bin_accum_serializer

Overview:
Successor to the fixed N-bin averaging wrapper. Accumulates BINS parallel unsigned FFT-magnitude bins over 2^log_avgs frames, with the average count set at runtime. Each completed average is captured into a snapshot buffer so accumulation continues while the buffer drains. The buffer is serialised MSB-first into N_OUT-bit words under valid/ready backpressure toward the ethernet packetiser.

Parameters:
N, 16, input bin width (unsigned)
BINS, 4, bins per input frame
N_OUT, 8, output word width; N % N_OUT == 0 required
MAX_LOG_AVGS, 7, max log2 of averages per period
SUM_WIDTH, 32, accumulator width; SUM_WIDTH >= N+MAX_LOG_AVGS required (elaboration $error otherwise)

Ports:
clk  in  1  system clock, all logic on rising edge
srst_n  in  1  synchronous active-low reset
in_valid  in  1  in_data holds one complete frame this cycle
in_data  in  BINS*N  bin b at [b*N +: N]
log_avgs  in  $clog2(MAX_LOG_AVGS+1)  averages per period = 2^log_avgs
out_data  out  N_OUT  serialised word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word when out_valid&&out_ready
out_last  out  1  final word of an average set
overflow  out  1  sticky: a completed average was discarded
busy  out  1  accumulation period in progress (frame count != 0)

Behaviour:
- Reset (srst_n=0 at an edge): accumulators=0, frame count=0, snapshot empty, out_valid=0, out_last=0, out_data=0, overflow=0, busy=0. Reset mid-drain abandons the set; no partial words follow.
- Accumulate FSM, states ACC_IDLE / ACC_RUN:
  - ACC_IDLE: on in_valid, latch log_avgs into L (clamped to MAX_LOG_AVGS). Load acc[b]=in_data[b]. Count=1. Go to ACC_RUN, unless L=0 (see complete).
  - ACC_RUN: on in_valid, acc[b]+=in_data[b] and count++. Changes to log_avgs mid-period are ignored.
  - Complete: the frame on which count reaches 2^L. avg[b]=(acc[b]+in_data[b])>>L, a combinational path including the current frame, truncated to N bits. Return to ACC_IDLE with accumulators cleared.
  - No in_valid: state holds.
- Snapshot / drain FSM, states DR_EMPTY / DR_SEND:
  - Complete in DR_EMPTY: snapshot <= avg at that edge. Word index=0. out_valid=1 from the next cycle (latency 1 cycle after the completing frame).
  - DR_SEND: word order is bin 0 first; within a bin, most-significant N_OUT slice first. Total W=BINS*N/N_OUT words.
  - A word transfers on out_valid&&out_ready, then the index advances. out_data/out_valid are stable while out_ready=0.
  - out_last=1 with word W-1. After its transfer, go to DR_EMPTY.
  - Complete while DR_SEND, except on the cycle the last word transfers: new average discarded, overflow<=1 (sticky until reset), current drain unaffected.
  - Complete on the same cycle as the last-word transfer: snapshot reloads and out_valid stays high (back-to-back sets, no bubble).
- Input is never back-pressured; frames are never dropped from accumulation.
- out_data/out_last are don't-care while out_valid=0. Bench checks them only when valid.

Optional Feature:
NBIN_ROUND_EN
- Defined: avg[b]=(sum + (L>0 ? 2^(L-1) : 0))>>L, round-half-up, saturated to 2^N-1. SUM_WIDTH guard bit covers the addition.
- Undefined: plain truncating shift; no rounding adder in the netlist.

Test Plan:
- BINS=4,N=16,N_OUT=8, log_avgs=2, 4 frames of bins {100,200,300,400}, out_ready=1 -> bytes 00,64,00,C8,01,2C,01,90 one per cycle, first byte 1 cycle after 4th frame; out_last only on 8th; overflow=0.
- log_avgs=0, one frame {0xFFFF,1,2,3} -> FF,FF,00,01,00,02,00,03. Then log_avgs=1, frames {1,..}{2,..} -> bin0 byte pair 00,01 (truncate); with NBIN_ROUND_EN -> 00,02.
- Backpressure: toggle out_ready 1,0,0,1 pattern -> word order unchanged; out_data/out_valid stable while stalled; exactly 8 transfers.
- Overflow: log_avgs=0, frames every cycle, out_ready=0 -> first set held, overflow=1 on 2nd frame. Release out_ready -> original set only, then an empty gap until the next completion.
- Back-to-back: log_avgs=3, out_ready=1, frames every cycle -> set k+1 starts the cycle after set k's out_last with no bubble; overflow=0.
- Reset: assert srst_n=0 after 3 of 8 words and mid-accumulation -> next cycle out_valid=0, busy=0. New sets after reset average only post-reset frames.
